// File: rtl/multi_layer_valid_ctrl_if.sv
// Control/status bundle between a layer-bank sequencer and whoever launches it.
// The sequencer takes the slave side; the launcher and MAC array observe via master.
interface multi_layer_valid_ctrl_if #(
  parameter int N_MACS   = 4,
  parameter int N_LAYERS = 2
);
  localparam int unsigned LW = ($clog2(N_LAYERS + 1) > 1) ? $clog2(N_LAYERS + 1) : 1;
  localparam int unsigned W  = N_MACS * N_LAYERS;

  logic          start;
  logic [LW-1:0] num_layers;
  logic [W-1:0]  valid_ctrl;
  logic [W-1:0]  clear;
  logic [LW-1:0] layer_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, num_layers,
    input  valid_ctrl, clear, layer_idx, busy, done
  );

  modport slave (
    input  start, num_layers,
    output valid_ctrl, clear, layer_idx, busy, done
  );
endinterface

// File: rtl/multi_layer_valid_ctrl.sv
// Sequences N_LAYERS MAC banks: clear a bank, walk a one-hot valid strobe over
// its MACs, idle GAP cycles, move to the next bank, pulse done at the end.
module multi_layer_valid_ctrl #(
  parameter int N_MACS   = 4,
  parameter int N_LAYERS = 2,
  parameter int GAP      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_layer_valid_ctrl_if.slave bus
);
  localparam int unsigned LW = ($clog2(N_LAYERS + 1) > 1) ? $clog2(N_LAYERS + 1) : 1;
  localparam int unsigned W  = N_MACS * N_LAYERS;
  localparam int unsigned MW = (N_MACS > 1) ? $clog2(N_MACS) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [W-1:0] ONE_BIT  = W'(1);
  localparam logic [W-1:0] BANK_ALL = W'({N_MACS{1'b1}});

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [LW-1:0] layers_q, layers_d;
  logic [MW-1:0] mac_q, mac_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [W-1:0]  valid_q, valid_d;
  logic [W-1:0]  clear_q, clear_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   base_d;

  // Next-state logic plus outputs decoded from the state being entered
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    layers_d = layers_q;
    mac_d    = mac_q;
    gap_d    = gap_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          layer_d = '0;
          if (bus.num_layers == '0) begin
            layers_d = LW'(1);
          end else if (32'(bus.num_layers) > 32'(N_LAYERS)) begin
            layers_d = LW'(N_LAYERS);
          end else begin
            layers_d = bus.num_layers;
          end
        end
      end
      S_CLEAR: begin
        mac_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mac_q == MW'(N_MACS - 1)) begin
          if (layer_q == layers_q - LW'(1)) begin
            state_d = S_DONE;
          end else if (GAP == 0) begin
            layer_d = layer_q + LW'(1);
            state_d = S_CLEAR;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else begin
          mac_d = mac_q + MW'(1);
        end
      end
      S_GAP: begin
        if (int'(gap_q) == GAP - 1) begin
          layer_d = layer_q + LW'(1);
          state_d = S_CLEAR;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    base_d  = 32'(layer_d) * 32'(N_MACS);
    valid_d = '0;
    clear_d = '0;
    if (state_d == S_RUN) begin
      valid_d = ONE_BIT << (base_d + 32'(mac_d));
    end
    if (state_d == S_CLEAR) begin
      clear_d = BANK_ALL << base_d;
    end
    busy_d = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      layers_q <= LW'(1);
      mac_q    <= '0;
      gap_q    <= '0;
      valid_q  <= '0;
      clear_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      layers_q <= layers_d;
      mac_q    <= mac_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.valid_ctrl = valid_q;
  assign bus.clear      = clear_q;
  assign bus.layer_idx  = layer_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_multi_layer_valid_ctrl.sv
// Bench for multi_layer_valid_ctrl: a timeline model derived from run length
// and cycle offset, a MAC-array accumulator model, and directed runs.
module tb_multi_layer_valid_ctrl;
  localparam int N_MACS   = 4;
  localparam int N_LAYERS = 2;
  localparam int GAP      = 2;
  localparam int LW       = 2;
  localparam int W        = N_MACS * N_LAYERS;
  localparam int PERIOD   = N_MACS + 1 + GAP;

  bit clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_layer_valid_ctrl_if #(.N_MACS(N_MACS), .N_LAYERS(N_LAYERS)) bus ();

  multi_layer_valid_ctrl #(.N_MACS(N_MACS), .N_LAYERS(N_LAYERS), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  int w [N_MACS] = '{2, 3, 5, 7};
  int acc[W];

  bit m_active = 1'b0;
  bit m_lknown = 1'b0;
  int m_t      = 0;
  int m_L      = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_layers(input int n);
    if (n == 0) return 1;
    if (n > N_LAYERS) return N_LAYERS;
    return n;
  endfunction

  function automatic int done_cycle(input int l);
    return l * (N_MACS + 1) + (l - 1) * GAP + 1;
  endfunction

  // Run model: m_t is the cycle number counted from the accepted start edge
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_lknown = 1'b1;
    end else if (m_active) begin
      if (m_t == done_cycle(m_L)) begin
        m_active = 1'b0;
        m_lknown = 1'b0;
      end else begin
        m_t++;
      end
    end else if (bus.start) begin
      m_active = 1'b1;
      m_t      = 1;
      m_L      = clamp_layers(int'(bus.num_layers));
    end
  end

  // MAC array: acc += a_in * weight on valid, zeroed on clear
  always @(negedge clk) begin
    for (int b = 0; b < W; b++) begin
      if (bus.clear[b] === 1'b1) acc[b] = 0;
      else if (bus.valid_ctrl[b] === 1'b1) acc[b] += 10 * w[b % N_MACS];
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    logic [W-1:0] e_valid, e_clear;
    logic         e_busy, e_done;
    int           l, off;
    #1;
    e_valid = '0;
    e_clear = '0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    l       = 0;
    if (m_active) begin
      if (m_t == done_cycle(m_L)) begin
        e_done = 1'b1;
      end else begin
        e_busy = 1'b1;
        l      = (m_t - 1) / PERIOD;
        off    = (m_t - 1) % PERIOD;
        if (off == 0) e_clear = W'({N_MACS{1'b1}}) << (l * N_MACS);
        else if (off <= N_MACS) e_valid = W'(1) << (l * N_MACS + off - 1);
      end
    end
    chk("valid_ctrl", 64'(bus.valid_ctrl), 64'(e_valid));
    chk("clear", 64'(bus.clear), 64'(e_clear));
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("done", 64'(bus.done), 64'(e_done));
    if (e_busy || (!m_active && m_lknown)) chk("layer_idx", 64'(bus.layer_idx), 64'(l));
    chk("onehot0", 64'($onehot0(bus.valid_ctrl)), 64'(1));
    chk("valid_clear_overlap", 64'(|(bus.valid_ctrl & bus.clear)), 64'(0));
    if (e_done) begin
      for (int b = 0; b < m_L; b++)
        for (int m = 0; m < N_MACS; m++)
          chk("acc", 64'(acc[b * N_MACS + m]), 64'(10 * w[m]));
    end
  end

  task automatic to_cycle(input int c);
    while (cur < c) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  // Start accepted at edge 0; returns in cycle 1
  task automatic launch(input int nl, input bit hold);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_layers = LW'(nl);
    @(posedge clk);
    #1;
    cur = 1;
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_layers = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_valid", 64'(bus.valid_ctrl), 64'(0));
    chk("rst_layer", 64'(bus.layer_idx), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Two-layer run
    launch(2, 1'b0);
    chk("two_clr0_c1", 64'(bus.clear), 64'h0F);
    to_cycle(5);  chk("two_v3_c5", 64'(bus.valid_ctrl), 64'h08);
    to_cycle(7);  chk("two_gap_c7", 64'({bus.valid_ctrl, bus.clear}), 64'h0);
    to_cycle(8);  chk("two_clr1_c8", 64'(bus.clear), 64'hF0);
    to_cycle(12); chk("two_v7_c12", 64'(bus.valid_ctrl), 64'h80);
    to_cycle(13); chk("two_done_c13", 64'({bus.done, bus.busy}), 64'h2);
    to_cycle(16);

    // Single layer
    launch(1, 1'b0);
    to_cycle(6); chk("one_done_c6", 64'(bus.done), 64'h1);
    to_cycle(9);

    // num_layers=0 clamps to 1; late num_layers change has no effect
    launch(0, 1'b0);
    to_cycle(3);
    @(negedge clk);
    bus.num_layers = LW'(2);
    to_cycle(6); chk("zero_done_c6", 64'(bus.done), 64'h1);
    to_cycle(9);

    // num_layers=3 clamps to 2
    launch(3, 1'b0);
    to_cycle(13); chk("three_done_c13", 64'(bus.done), 64'h1);
    to_cycle(16);

    // start pulsed mid-run is neither honoured nor queued
    launch(2, 1'b0);
    to_cycle(4);
    @(negedge clk);
    bus.start = 1'b1;
    to_cycle(5);
    @(negedge clk);
    bus.start = 1'b0;
    to_cycle(13); chk("ign_done_c13", 64'(bus.done), 64'h1);
    to_cycle(15); chk("ign_no_rerun_c15", 64'({bus.busy, bus.clear}), 64'h0);
    to_cycle(18);

    // Mid-run reset, then a clean rerun
    launch(2, 1'b0);
    to_cycle(10);
    @(negedge clk);
    rst = 1'b1;
    to_cycle(11);
    chk("mrst_c11", 64'({bus.busy, bus.valid_ctrl, bus.clear, bus.layer_idx}), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    to_cycle(14); chk("mrst_no_done", 64'(bus.done), 64'h0);
    launch(2, 1'b0);
    to_cycle(13); chk("rerun_done_c13", 64'(bus.done), 64'h1);
    to_cycle(16);

    // start held high relaunches on the IDLE cycle after DONE
    launch(1, 1'b1);
    to_cycle(8); chk("hold_reclr_c8", 64'(bus.clear), 64'h0F);
    @(negedge clk);
    bus.start = 1'b0;
    to_cycle(20);

    // Reset wins over start
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_prio_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
